// File: rtl/mmcm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// mmcm_reset_sequencer
//
// Purpose:
//   Drives the MMCM reset and waits until LOCKED is high and stays high
//   before it declares the clock ready. On a lock timeout or a loss of lock
//   it retries the whole sequence. After MAX_RETRIES retries it gives up and
//   parks in FAIL until RST or I_RESTART.
//
// Ports:
//   CLK         in   fabric clock (BUFG-driven)
//   RST         in   synchronous, active-high reset of this block
//   I_LOCKED    in   MMCM LOCKED, asynchronous to CLK (synchronised here)
//   I_RESTART   in   synchronous; restarts the sequence and clears retries
//   O_MMCM_RST  out  reset to the MMCM/tester, registered
//   O_READY     out  MMCM locked and stable, registered
//   O_FAIL      out  retries exhausted, registered
//   O_RETRIES   out  retries consumed so far
//   O_STATE     out  0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
// ---------------------------------------------------------------------------
module mmcm_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       I_LOCKED,
    input  logic       I_RESTART,
    output logic       O_MMCM_RST,
    output logic       O_READY,
    output logic       O_FAIL,
    output logic [3:0] O_RETRIES,
    output logic [2:0] O_STATE
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // One counter serves every timed state, so it is sized for the largest
    // limit. Each limit forces a state exit, so the counter never wraps.
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic             lk_meta_q, lk_s_q;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             retry;

    // -----------------------------------------------------------------------
    // State register, counters, synchroniser and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            retries_q  <= '0;
            lk_meta_q  <= 1'b0;
            lk_s_q     <= 1'b0;
            mmcm_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            lk_meta_q  <= I_LOCKED;
            lk_s_q     <= lk_meta_q;
            mmcm_rst_q <= mmcm_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A retry is an action that lands in RESET or FAIL; it
    // is resolved after the per-state decision so all states share it.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        retry     = 1'b0;

        if (I_RESTART) begin
            state_d   = ST_RESET;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a timeout on the same cycle.
                    if (lk_s_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lk_s_q) begin
                        retry = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lk_s_q) begin
                        retry = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase

            if (retry) begin
                cnt_d = '0;
                if (retries_q == RETRY_LIMIT) begin
                    state_d = ST_FAIL;
                end else begin
                    retries_d = retries_q + 4'd1;
                    state_d   = ST_RESET;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs change in
    // the same update as the state register.
    // -----------------------------------------------------------------------
    always_comb begin
        mmcm_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d    = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    assign O_MMCM_RST = mmcm_rst_q;
    assign O_READY    = ready_q;
    assign O_FAIL     = fail_q;
    assign O_RETRIES  = retries_q;
    assign O_STATE    = state_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mmcm_reset_sequencer
//
// Purpose:
//   Self-checking bench for mmcm_reset_sequencer with small parameters.
//   Directed scenarios (lock, timeout/fail, lock loss, glitch, restart, reset
//   in RUN) followed by randomized lock/restart/reset traffic. Every cycle the
//   outputs are compared against a phase/elapsed-time reference model.
// ---------------------------------------------------------------------------
module tb_mmcm_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    // Phase codes as reported on O_STATE.
    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       I_LOCKED = 1'b0;
    logic       I_RESTART = 1'b0;
    logic       O_MMCM_RST;
    logic       O_READY;
    logic       O_FAIL;
    logic [3:0] O_RETRIES;
    logic [2:0] O_STATE;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_phase   = PH_RESET;
    int m_elapsed = 0;
    int m_retries = 0;
    bit lk_hist[$];

    mmcm_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .I_LOCKED  (I_LOCKED),
        .I_RESTART (I_RESTART),
        .O_MMCM_RST(O_MMCM_RST),
        .O_READY   (O_READY),
        .O_FAIL    (O_FAIL),
        .O_RETRIES (O_RETRIES),
        .O_STATE   (O_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 25)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    task automatic model_retry();
        if (m_retries == MAX_RETRIES) begin
            model_enter(PH_FAIL);
        end else begin
            m_retries++;
            model_enter(PH_RESET);
        end
    endtask

    // Advance the model by one clock edge given the inputs sampled there.
    // The lock seen by the decisions is the input from two edges earlier.
    task automatic model_edge(input bit rst, input bit lk, input bit rs);
        bit lk_seen;
        if (rst) begin
            model_enter(PH_RESET);
            m_retries = 0;
            lk_hist.delete();
            lk_hist.push_back(1'b0);
            lk_hist.push_back(1'b0);
            return;
        end
        lk_seen = lk_hist.pop_front();
        lk_hist.push_back(lk);
        if (rs) begin
            model_enter(PH_RESET);
            m_retries = 0;
            return;
        end
        case (m_phase)
            PH_RESET:
                if (m_elapsed + 1 >= RST_CYCLES) model_enter(PH_WAIT);
                else m_elapsed++;
            PH_WAIT:
                if (lk_seen) model_enter(PH_STABLE);
                else if (m_elapsed + 1 >= LOCK_TIMEOUT) model_retry();
                else m_elapsed++;
            PH_STABLE:
                if (!lk_seen) model_retry();
                else if (m_elapsed + 1 >= STABLE_CYCLES) model_enter(PH_RUN);
                else m_elapsed++;
            PH_RUN:
                if (!lk_seen) model_retry();
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check_eq("state",    O_STATE,    m_phase);
        check_eq("mmcm_rst", O_MMCM_RST, (m_phase == PH_RESET || m_phase == PH_FAIL) ? 1 : 0);
        check_eq("ready",    O_READY,    (m_phase == PH_RUN) ? 1 : 0);
        check_eq("fail",     O_FAIL,     (m_phase == PH_FAIL) ? 1 : 0);
        check_eq("retries",  O_RETRIES,  m_retries);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after an edge; outputs are compared 1 unit
    // after the next edge.
    task automatic step(input bit rst, input bit lk, input bit rs);
        RST       = rst;
        I_LOCKED  = lk;
        I_RESTART = rs;
        @(posedge CLK);
        model_edge(rst, lk, rs);
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input bit lk);
        for (int i = 0; i < n; i++) step(1'b0, lk, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ready_seen;
        bit lk;
        int len;

        // 1: reset with lock already present, reach RUN.
        step(1'b1, 1'b1, 1'b0);
        check_eq("s1_rst_mmcm", O_MMCM_RST, 1);
        check_eq("s1_rst_state", O_STATE, 0);
        for (int i = 0; i < RST_CYCLES; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_eq("s1_mmcm_hold", O_MMCM_RST, (i < RST_CYCLES - 1) ? 1 : 0);
        end
        run(16, 1'b1);
        check_eq("s1_run_state", O_STATE, 3);
        check_eq("s1_run_ready", O_READY, 1);
        check_eq("s1_run_retries", O_RETRIES, 0);

        // 3: lock loss in RUN, retry, relock.
        run(3, 1'b0);
        check_eq("s3_ready_drop", O_READY, 0);
        check_eq("s3_retries", O_RETRIES, 1);
        check_eq("s3_mmcm", O_MMCM_RST, 1);
        run(20, 1'b1);
        check_eq("s3_relock", O_STATE, 3);

        // 4: two-cycle glitch while in STABLE.
        step(1'b0, 1'b1, 1'b1);
        run(8, 1'b1);
        run(2, 1'b0);
        ready_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (O_READY === 1'b1) ready_seen = 1'b1;
        end
        check_eq("s4_no_ready", ready_seen, 0);
        check_eq("s4_retries", O_RETRIES, 1);
        run(20, 1'b1);
        check_eq("s4_run", O_STATE, 3);

        // 2: lock never arrives -> FAIL after MAX_RETRIES retries.
        step(1'b0, 1'b0, 1'b1);
        run(150, 1'b0);
        check_eq("s2_state", O_STATE, 4);
        check_eq("s2_fail", O_FAIL, 1);
        check_eq("s2_mmcm", O_MMCM_RST, 1);
        check_eq("s2_retries", O_RETRIES, 2);
        run(20, 1'b1);
        check_eq("s2_absorb", O_STATE, 4);

        // 5: restart out of FAIL, held restart, RST+restart together.
        step(1'b0, 1'b1, 1'b1);
        check_eq("s5_state", O_STATE, 0);
        check_eq("s5_retries", O_RETRIES, 0);
        check_eq("s5_fail", O_FAIL, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("s5_hold", O_STATE, 0);
        run(20, 1'b1);
        run(40, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("s5_both_state", O_STATE, 0);
        check_eq("s5_both_retries", O_RETRIES, 0);

        // 6: RST while in RUN.
        run(20, 1'b1);
        check_eq("s6_in_run", O_STATE, 3);
        step(1'b1, 1'b1, 1'b0);
        check_eq("s6_ready", O_READY, 0);
        check_eq("s6_mmcm", O_MMCM_RST, 1);
        check_eq("s6_state", O_STATE, 0);

        // Randomized traffic checked every cycle by the model.
        for (int s = 0; s < 300; s++) begin
            lk  = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 45);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 149) == 0),
                     lk,
                     ($urandom_range(0, 59) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
